// File: rtl/mdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package mdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  localparam logic [4:0]  MUL_OP      = 5'b00110;
  localparam logic [4:0]  DIV_OP      = 5'b00111;
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;
  localparam logic [4:0]  RSTATUS_REG = 5'd30;

  function automatic logic [31:0] rstatus_code(input op_e op);
    return (op == OP_MUL) ? RSTATUS_MUL : RSTATUS_DIV;
  endfunction

endpackage

// File: rtl/mdiv_ctrl_if.sv
// X-stage request, multdiv core return and writeback bundle of the mdiv controller.
interface mdiv_ctrl_if;
  logic        is_mult;
  logic        is_div;
  logic        flush;
  logic [31:0] x_ir;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        mdiv_valid;
  logic [31:0] mdiv_result;
  logic [4:0]  mdiv_rd;
  logic        mdiv_exception;

  modport slave (
    input  is_mult, is_div, flush, x_ir, data_result, data_exception, data_resultRDY,
    output ctrl_mult, ctrl_div, stall, mdiv_valid, mdiv_result, mdiv_rd, mdiv_exception
  );

  modport master (
    output is_mult, is_div, flush, x_ir, data_result, data_exception, data_resultRDY,
    input  ctrl_mult, ctrl_div, stall, mdiv_valid, mdiv_result, mdiv_rd, mdiv_exception
  );
endinterface

// File: rtl/mdiv_watchdog.sv
// Saturating busy-cycle counter; expired flags the last allowed cycle of an operation.
module mdiv_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  // NOTE: default assignment first so every path assigns count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear)                       count_d = '0;
    else if (enable && count_q != '1) count_d = count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                count_q <= '0;
    else if (clear || enable) count_q <= count_d;
  end

  assign expired = enable && (count_q >= LAST);
endmodule

// File: rtl/mdiv_ctrl.sv
// Execute-stage sequencer for the multdiv core: start pulse, stall, bounded wait, writeback.
module mdiv_ctrl
  import mdiv_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic       clock,
  input  logic       reset,
  mdiv_ctrl_if.slave bus
);
  state_e      state_q, state_d;
  op_e         op_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        req, start, finish, busy, expired;

  assign req    = (bus.is_mult | bus.is_div) & ~bus.flush;
  assign busy   = (state_q == BUSY);
  assign start  = (state_q == IDLE) & req;
  assign finish = busy & ~bus.flush & (bus.data_resultRDY | expired);

  mdiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (start),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (bus.flush) state_d = IDLE;
               else if (bus.data_resultRDY || expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= OP_MUL;
      rd_q <= '0;
    end else if (start) begin
      op_q <= bus.is_mult ? OP_MUL : OP_DIV;
      rd_q <= bus.x_ir[26:22];
    end
  end

  // A timeout completes as result 0 with the exception flag; a real result takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (finish) begin
      result_q <= bus.data_resultRDY ? bus.data_result : '0;
      exc_q    <= bus.data_resultRDY ? bus.data_exception : 1'b1;
    end
  end

  always_comb begin
    bus.ctrl_mult      = 1'b0;
    bus.ctrl_div       = 1'b0;
    bus.stall          = 1'b0;
    bus.mdiv_valid     = 1'b0;
    bus.mdiv_result    = '0;
    bus.mdiv_rd        = '0;
    bus.mdiv_exception = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          bus.ctrl_mult = req & bus.is_mult;
          bus.ctrl_div  = req & ~bus.is_mult;
          bus.stall     = req;
        end
        BUSY: bus.stall = ~bus.flush;
        DONE: if (!bus.flush) begin
          bus.mdiv_valid     = 1'b1;
          bus.mdiv_exception = exc_q;
          bus.mdiv_rd        = exc_q ? RSTATUS_REG : rd_q;
          bus.mdiv_result    = exc_q ? rstatus_code(op_q) : result_q;
        end
        default: ;
      endcase
    end
  end

  // The decode arrives on is_mult/is_div; the remaining instruction fields are not needed here.
  logic unused_x_ir;
  assign unused_x_ir = ^{bus.x_ir[31:27], bus.x_ir[21:0]} |
                       (bus.x_ir[6:2] == MUL_OP) | (bus.x_ir[6:2] == DIV_OP);
endmodule

// File: tb/tb_mdiv_ctrl.sv
// Self-checking bench for mdiv_ctrl: directed scenarios plus randomized operations.
module tb_mdiv_ctrl;
  localparam int TIMEOUT = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mdiv_ctrl_if bus ();

  mdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit m, input bit d, input bit s, input bit v,
                            input bit e, input logic [4:0] rd, input logic [31:0] res);
    check({tag, ".ctrl_mult"}, 32'(bus.ctrl_mult), 32'(m));
    check({tag, ".ctrl_div"},  32'(bus.ctrl_div),  32'(d));
    check({tag, ".stall"},     32'(bus.stall),     32'(s));
    check({tag, ".valid"},     32'(bus.mdiv_valid), 32'(v));
    check({tag, ".exc_rd"},    {26'd0, bus.mdiv_exception, bus.mdiv_rd}, {26'd0, e, rd});
    check({tag, ".result"},    bus.mdiv_result, res);
  endtask

  task automatic drive(input bit m, input bit d, input bit fl, input logic [31:0] ir,
                       input bit rdy, input logic [31:0] res, input bit exc);
    bus.is_mult        = m;
    bus.is_div         = d;
    bus.flush          = fl;
    bus.x_ir           = ir;
    bus.data_resultRDY = rdy;
    bus.data_result    = res;
    bus.data_exception = exc;
  endtask

  // Cycles with no request (selects masked by flush); an optional late core result is ignored.
  task automatic idle_cycles(input int n, input int rdy_at);
    for (int i = 0; i < n; i++) begin
      bit m, d;
      @(posedge clock); #1;
      m = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      drive(m, d, m | d, $urandom, i == rdy_at, $urandom, 1'($urandom_range(0, 1)));
      #3;
      check_outs("idle", 0, 0, 0, 0, 0, 5'd0, 32'd0);
    end
  endtask

  // One operation from the start cycle (c = 0) through DONE, or until the flush cycle.
  // n_ready: cycle the core answers (<1 or >TIMEOUT means it never answers in time).
  task automatic run_op(input bit mul, input bit both, input logic [4:0] rd, input logic [31:0] res,
                        input bit exc_in, input int n_ready, input int flush_at);
    bit          in_time = (n_ready >= 1) && (n_ready <= TIMEOUT);
    int          lat     = in_time ? n_ready : TIMEOUT;
    int          last    = (flush_at >= 0 && flush_at <= lat) ? flush_at : lat + 1;
    bit          e_exc   = !in_time || exc_in;
    logic [4:0]  e_rd    = e_exc ? 5'd30 : rd;
    logic [31:0] e_res   = e_exc ? (mul ? 32'd4 : 32'd5) : res;
    for (int c = 0; c <= last; c++) begin
      logic [31:0] ir;
      bit          fl, hit, s, v;
      ir  = $urandom;
      if (c == 0) ir[26:22] = rd;
      fl  = (c == flush_at);
      hit = (c == n_ready) && (n_ready >= 1);
      @(posedge clock); #1;
      drive(mul, !mul || both, fl, ir, hit, hit ? res : $urandom,
            hit ? exc_in : 1'($urandom_range(0, 1)));
      #3;
      s = (c <= lat) && !fl;
      v = (c == lat + 1) && !fl;
      check_outs(mul ? "mul" : "div", (c == 0) && !fl && mul, (c == 0) && !fl && !mul, s, v,
                 v && e_exc, v ? e_rd : 5'd0, v ? e_res : 32'd0);
    end
  endtask

  initial begin
    drive(1, 0, 0, 32'h0000_0000, 1, 32'hdead_beef, 1);
    #3;
    check_outs("reset", 0, 0, 0, 0, 0, 5'd0, 32'd0);
    @(posedge clock); #1;
    drive(0, 0, 0, '0, 0, '0, 0);
    reset = 1'b0;
    idle_cycles(2, -1);

    // Multiply with a 17-cycle core, then divide-by-zero at N = 33.
    run_op(1, 0, 5'd5, 32'h0000_0C35, 0, 17, -1);
    idle_cycles(1, -1);
    run_op(0, 0, 5'd9, $urandom, 1, 33, -1);
    idle_cycles(1, -1);

    // Core never answers; the core answering exactly on the last cycle still wins.
    run_op(1, 0, 5'd12, $urandom, 0, 0, -1);
    run_op(0, 0, 5'd3, 32'h1234_5678, 0, TIMEOUT, -1);
    run_op(1, 1, 5'd0, 32'h0000_0001, 0, 1, -1);
    idle_cycles(1, -1);

    // Flush in BUSY cycle 3 with the core answering 5 cycles later.
    run_op(1, 0, 5'd7, $urandom, 0, 99, 3);
    idle_cycles(7, 4);
    // Flush in BUSY, then a new request right away; flush in DONE; flush on the start cycle.
    run_op(0, 0, 5'd17, $urandom, 0, 6, 2);
    run_op(1, 0, 5'd21, $urandom, 0, 4, 5);
    run_op(0, 0, 5'd22, $urandom, 0, 4, 0);
    idle_cycles(1, -1);

    // Asynchronous reset in BUSY cycle 10.
    for (int c = 0; c <= 10; c++) begin
      @(posedge clock); #1;
      drive(1, 0, 0, {5'd0, 5'd7, 22'd0}, 0, $urandom, 0);
      #3;
      check("pre_reset.stall", 32'(bus.stall), 32'd1);
    end
    reset = 1'b1;
    #1;
    check_outs("mid_reset", 0, 0, 0, 0, 0, 5'd0, 32'd0);
    @(posedge clock); #1;
    check_outs("held_reset", 0, 0, 0, 0, 0, 5'd0, 32'd0);
    drive(0, 0, 0, '0, 0, '0, 0);
    reset = 1'b0;
    run_op(1, 0, 5'd11, 32'hcafe_0001, 0, 3, -1);

    // Back-to-back: request held through DONE, next start in the following cycle.
    run_op(1, 0, 5'd1, $urandom, 0, 2, -1);
    run_op(1, 0, 5'd2, $urandom, 0, 1, -1);
    run_op(0, 0, 5'd3, $urandom, 1, 5, -1);
    idle_cycles(1, -1);

    for (int k = 0; k < 25; k++) begin
      bit mul = 1'($urandom_range(0, 1));
      int n   = $urandom_range(0, TIMEOUT + 5);
      int fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n + 1) : -1;
      run_op(mul, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             1'($urandom_range(0, 1)), n, fl);
      idle_cycles($urandom_range(0, 2), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdiv_ctrl.md
# mdiv_ctrl

Sequencing controller for the multi-cycle multiply/divide unit in the execute stage. It detects a `mul`/`div` in X, issues a one-cycle start pulse to the operand latch and multdiv core, and stalls F/D/X until the core reports a result. It then presents a one-cycle writeback bundle (result, destination register, exception status) to the X/M latch. A cycle-count watchdog bounds every operation, and a flush aborts an operation in flight.

## Interface
- `TIMEOUT`, default 40: maximum number of BUSY cycles before the operation is forced to complete with an exception.
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high; returns the block to IDLE.
- `is_mult`  input  1  X-stage instruction is `mul` (ALU opcode 00110).
- `is_div`  input  1  X-stage instruction is `div` (ALU opcode 00111).
- `flush`  input  1  branch/jump flush of X; aborts any operation.
- `x_ir`  input  32  X-stage instruction word.
- `data_result`  input  32  multdiv core result.
- `data_exception`  input  1  multdiv core overflow / divide-by-zero flag.
- `data_resultRDY`  input  1  multdiv core result valid.
- `ctrl_mult`  output  1  start pulse for a multiply (to the operand latch and core).
- `ctrl_div`  output  1  start pulse for a divide.
- `stall`  output  1  freeze PC, F/D and D/X latches; hold X.
- `mdiv_valid`  output  1  one-cycle writeback strobe to X/M.
- `mdiv_result`  output  32  value to write.
- `mdiv_rd`  output  5  destination register.
- `mdiv_exception`  output  1  completed operation raised an exception.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - A request is `req = (is_mult | is_div) & ~flush`. If both select lines are high, the multiply wins.
  - On `req`, drive `ctrl_mult` or `ctrl_div` high and `stall` high, both combinationally, for this cycle only.
  - On the same edge, capture `op` (mult/div) and `rd = x_ir[26:22]`, clear the counter and go to BUSY.
- **BUSY**
  - `stall` = 1 and the counter increments every cycle.
  - On `data_resultRDY`: capture `data_result` and `data_exception`, then go to DONE.
  - If the counter reaches `TIMEOUT - 1` without `data_resultRDY`: capture result 0 with exception = 1, then go to DONE.
  - If both happen in the same cycle, `data_resultRDY` wins.
- **DONE**
  - `stall` = 0 and `mdiv_valid` = 1 for exactly one cycle.
  - X/M latches the held instruction together with the mdiv bundle.
  - `is_mult`/`is_div` are ignored this cycle, so the held `mul`/`div` does not retrigger.
  - Next state is IDLE.
- **Exception writeback**
  - With exception = 1: `mdiv_rd` = 30 and `mdiv_result` = 4 for a multiply, 5 for a divide.
  - Otherwise `mdiv_rd` = the captured rd and `mdiv_result` = the captured core result.
- **Flush**
  - In BUSY: go to IDLE on the next edge. `stall` drops combinationally in the flush cycle and no `mdiv_valid` is produced.
  - A late `data_resultRDY` arriving in IDLE is ignored.
  - In DONE: `mdiv_valid` is suppressed.
- **rd = 0**: the write proceeds through `mdiv_valid` as normal; the regfile discards it.
- **Reset**: asynchronous and valid at any state, including mid-operation. It forces IDLE, clears the counter, op, rd and result registers, and gates every output to 0 while asserted.

## Timing
- **Output reset values**: `ctrl_mult`, `ctrl_div`, `stall`, `mdiv_valid`, `mdiv_exception` = 0; `mdiv_result` = 0; `mdiv_rd` = 0.
- **Latency**
  - With the core asserting `data_resultRDY` N cycles after the start pulse (N ≥ 1), `mdiv_valid` rises N+1 cycles after the start cycle.
  - `stall` is high for N+1 cycles: the start cycle plus N BUSY cycles.
- **Timeout**: forced completion after `TIMEOUT` BUSY cycles; `mdiv_valid` rises at cycle `TIMEOUT + 1` after start.
- **Handshake**
  - Start pulses are exactly one cycle wide and never both high.
  - At most one operation is in flight.
  - `data_resultRDY` is sampled only in BUSY.
- **Back-to-back**: a new request is accepted in the IDLE cycle immediately after DONE, so the minimum spacing between start pulses is N+2 cycles.
- **Counter**: width `$clog2(TIMEOUT)+1` bits; it saturates and never wraps.

## Structure
- **Shared package `mdiv_pkg`**
  - State encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10).
  - ALU opcodes `MUL_OP` = 5'b00110 and `DIV_OP` = 5'b00111.
  - Status codes `RSTATUS_MUL` = 4 and `RSTATUS_DIV` = 5, and `RSTATUS_REG` = 30.
- **Sub-module `mdiv_watchdog`**
  - Parameterised cycle counter with `clear` and `enable` inputs and an `expired` output.
  - Instantiated once; used only in BUSY.
- All registers use `dffe_ref`-style enabled flops with asynchronous clear tied to `reset`.

## Test plan
- **Multiply, 17-cycle core**: `is_mult` = 1, `x_ir[26:22]` = 5, core returns 0x0000_0C35 at N = 17.
  - `ctrl_mult` is high for 1 cycle and `stall` for 18 cycles.
  - `mdiv_valid` pulses once with rd = 5 and result = 0x0000_0C35.
- **Divide by zero**: `is_div` = 1, rd = 9, core returns with `data_exception` = 1 at N = 33.
  - `mdiv_valid` pulses with rd = 30, result = 5 and `mdiv_exception` = 1.
- **Timeout**: `TIMEOUT` = 40 and `data_resultRDY` is never asserted.
  - At cycle 41: `mdiv_valid` = 1, `mdiv_exception` = 1, rd = 30, result = 4 for a multiply.
  - `stall` drops in that same cycle.
- **Flush mid-op**: `flush` in BUSY cycle 3.
  - `stall` = 0 in that cycle, the state is IDLE on the next edge, and no `mdiv_valid` is produced.
  - `data_resultRDY` arriving 5 cycles later causes no output.
- **Reset mid-op**: assert `reset` asynchronously in BUSY cycle 10.
  - All outputs go to 0 immediately.
  - After release, a new `mul` starts cleanly.
- **Back-to-back**: keep `is_mult` high through the DONE cycle, then hold it high for a second instruction.
  - No retrigger occurs in DONE.
  - The second `ctrl_mult` fires in the cycle immediately after DONE.
